mult_seq_ctrl: RTL



---
 rtl/mult_seq_pkg.sv | 27 ++
 rtl/dadda16x16_3_2.sv | 18 +
 rtl/dadda32x32_3_2.sv | 18 +
 rtl/dadda8x8_3_2.sv | 18 +
 rtl/dadda_csa_core.sv | 36 +++
 rtl/mult_seq_ctrl.sv | 168 ++++++++++++++++
 6 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the iterative wide multiplier sequencer.
//   state_e     : sequencer FSM states
//   Step*       : 2-bit partial-product step encodings; bit 0 selects the high half
//                 of operand a, bit 1 selects the high half of operand b
//   step_shift  : left shift applied to a step's partial product for half width w
package mult_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    localparam logic [1:0] StepLl = 2'd0;  // aL*bL
    localparam logic [1:0] StepHl = 2'd1;  // aH*bL
    localparam logic [1:0] StepLh = 2'd2;  // aL*bH
    localparam logic [1:0] StepHh = 2'd3;  // aH*bH

    function automatic int unsigned step_shift(input logic [1:0] step, input int unsigned w);
        case (step)
            StepLl:         return 0;
            StepHl, StepLh: return w;
            default:        return 2 * w;
        endcase
    endfunction

endpackage

// File: rtl/dadda16x16_3_2.sv
// 16x16 unsigned combinational multiplier, 3:2-compressor reduction.
//   a, b : 16-bit operands
//   p    : 32-bit product
module dadda16x16_3_2 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    dadda_csa_core #(
        .Width(16)
    ) u_core (
        .a(a),
        .b(b),
        .p(p)
    );

endmodule

// File: rtl/dadda32x32_3_2.sv
// 32x32 unsigned combinational multiplier, 3:2-compressor reduction.
//   a, b : 32-bit operands
//   p    : 64-bit product
module dadda32x32_3_2 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    dadda_csa_core #(
        .Width(32)
    ) u_core (
        .a(a),
        .b(b),
        .p(p)
    );

endmodule

// File: rtl/dadda8x8_3_2.sv
// 8x8 unsigned combinational multiplier, 3:2-compressor reduction.
//   a, b : 8-bit operands
//   p    : 16-bit product
module dadda8x8_3_2 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    dadda_csa_core #(
        .Width(8)
    ) u_core (
        .a(a),
        .b(b),
        .p(p)
    );

endmodule

// File: rtl/dadda_csa_core.sv
// Combinational unsigned Width x Width multiplier built from rows of 3:2 compressors.
// Partial-product rows are folded one at a time into a carry-save pair, then a single
// carry-propagate add produces the product.
//   a, b : unsigned operands
//   p    : full 2*Width-bit product
module dadda_csa_core #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0]   a,
    input  logic [Width-1:0]   b,
    output logic [2*Width-1:0] p
);

    localparam int unsigned PW = 2 * Width;

    logic [PW-1:0] row   [Width];
    logic [PW-1:0] sum   [Width];
    logic [PW-1:0] carry [Width];

    for (genvar i = 0; i < Width; i++) begin : g_rows
        assign row[i] = b[i] ? ({{Width{1'b0}}, a} << i) : '0;
    end

    assign sum[0]   = row[0];
    assign carry[0] = '0;

    // The exact running sum always fits in PW bits, so dropping the top carry bit is safe.
    for (genvar i = 1; i < Width; i++) begin : g_csa
        assign sum[i]   = sum[i-1] ^ carry[i-1] ^ row[i];
        assign carry[i] = ((sum[i-1] & carry[i-1]) | (sum[i-1] & row[i]) |
                           (carry[i-1] & row[i])) << 1;
    end

    assign p = sum[Width-1] + carry[Width-1];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative 2W x 2W unsigned multiplier that time-shares one W x W Dadda multiplier.
// Operands are split into halves; up to four partial products are issued on successive
// cycles and accumulated with the proper shifts.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_a, in_b latched on accept
//   out_valid/out_ready : product handshake; out_p held until taken
//   busy                : high whenever the sequencer is not idle
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned HALF_W    = 16,
    parameter bit          SKIP_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*HALF_W-1:0] in_a,
    input  logic [2*HALF_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*HALF_W-1:0] out_p,
    output logic              busy
);

    localparam int unsigned W  = HALF_W;
    localparam int unsigned OW = 2 * HALF_W;
    localparam int unsigned PW = 4 * HALF_W;

    state_e        state_q, state_d;
    logic [OW-1:0] a_q, b_q;
    logic [1:0]    step_q, step_d;
    logic [PW-1:0] acc_q, acc_d;
    logic          load;

    logic [W-1:0]  a_lo, a_hi, b_lo, b_hi;
    logic [W-1:0]  mul_a, mul_b;
    logic [OW-1:0] pp;
    logic [PW-1:0] pp_shifted;
    logic [3:0]    step_en;
    logic [1:0]    next_step;
    logic          next_found;

    assign a_lo = a_q[W-1:0];
    assign a_hi = a_q[OW-1:W];
    assign b_lo = b_q[W-1:0];
    assign b_hi = b_q[OW-1:W];

    // Step 0 always runs so the accumulator is written at least once per product.
    assign step_en[0] = 1'b1;
    assign step_en[1] = !SKIP_ZERO || ((a_hi != '0) && (b_lo != '0));
    assign step_en[2] = !SKIP_ZERO || ((a_lo != '0) && (b_hi != '0));
    assign step_en[3] = !SKIP_ZERO || ((a_hi != '0) && (b_hi != '0));

    // Lowest enabled step above the current one; descending loop so the smallest wins.
    always_comb begin
        next_step  = step_q;
        next_found = 1'b0;
        for (int s = 3; s >= 1; s--) begin
            if ((s > int'(step_q)) && step_en[s]) begin
                next_step  = 2'(s);
                next_found = 1'b1;
            end
        end
    end

    assign mul_a      = step_q[0] ? a_hi : a_lo;
    assign mul_b      = step_q[1] ? b_hi : b_lo;
    assign pp_shifted = {{OW{1'b0}}, pp} << step_shift(step_q, W);

    if (HALF_W == 8) begin : g_mul8
        dadda8x8_3_2 u_mul (
            .a(mul_a),
            .b(mul_b),
            .p(pp)
        );
    end else if (HALF_W == 16) begin : g_mul16
        dadda16x16_3_2 u_mul (
            .a(mul_a),
            .b(mul_b),
            .p(pp)
        );
    end else if (HALF_W == 32) begin : g_mul32
        dadda32x32_3_2 u_mul (
            .a(mul_a),
            .b(mul_b),
            .p(pp)
        );
    end else begin : g_mul_generic
        dadda_csa_core #(
            .Width(HALF_W)
        ) u_mul (
            .a(mul_a),
            .b(mul_b),
            .p(pp)
        );
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            step_q <= StepLl;
            acc_q  <= '0;
        end else begin
            if (load) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            step_q <= step_d;
            acc_q  <= acc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StMul;
                    step_d  = StepLl;
                    acc_d   = '0;
                    load    = 1'b1;
                end
            end
            StMul: begin
                acc_d = acc_q + pp_shifted;
                if (next_found) begin
                    step_d = next_step;
                end else begin
                    state_d = StDone;
                    step_d  = StepLl;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_p     = acc_q;
    end

endmodule
